// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem write-back path.
package fpu_ss_pkg;

  localparam int unsigned NumFpRegs = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegAddrW  = $clog2(NumFpRegs);

  typedef struct packed {
    logic [RegAddrW-1:0]  rd;
    logic [DataWidth-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_FPU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/fpu_ss_wb_buffer.sv
// One-entry valid/ready holding register for a write-back request.
module fpu_ss_wb_buffer
  import fpu_ss_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    valid_i,
  output logic    ready_o,
  input  wb_req_t req_i,
  input  logic    drain_i,
  output logic    full_o,
  output wb_req_t req_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;
  logic    load;

  // ready depends only on stored state and the drain grant, never on valid_i
  always_comb begin
    ready_o = !full_q | drain_i;
    load    = valid_i & ready_o;
    full_d  = full_q;
    req_d   = req_q;
    if (load) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Merges FPU results and load data onto the single regfile write port and tracks pending writes.
// Optional same-cycle write forwarding is enabled with FPU_SS_WB_FWD_EN.
module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [RegAddrW-1:0]  issue_rd_i,
  output logic [NumFpRegs-1:0] sb_busy_o,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [RegAddrW-1:0]  fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_data_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [RegAddrW-1:0]  mem_rd_i,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic                 rf_we_o,
  output logic [RegAddrW-1:0]  rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
`ifdef FPU_SS_WB_FWD_EN
  ,
  input  logic [2:0][RegAddrW-1:0] fwd_raddr_i,
  output logic [2:0]               fwd_hit_o,
  output logic [DataWidth-1:0]     fwd_data_o
`endif
);

  wb_req_t              fpu_req_in, mem_req_in;
  wb_req_t              fpu_req, mem_req;
  logic                 fpu_full, mem_full;
  logic                 fpu_drain, mem_drain;
  logic                 fpu_load, mem_load;
  logic                 grant_vld;
  wb_src_e              grant;
  wb_src_e              rr_last_q, rr_last_d;
  logic                 age_q, age_d;      // 1: MEM entry is older than FPU entry
  logic [NumFpRegs-1:0] sb_q, sb_d;

  always_comb begin
    fpu_req_in = '{rd: fpu_rd_i, data: fpu_data_i};
    mem_req_in = '{rd: mem_rd_i, data: mem_data_i};
  end

  fpu_ss_wb_buffer u_fpu_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (fpu_valid_i),
    .ready_o (fpu_ready_o),
    .req_i   (fpu_req_in),
    .drain_i (fpu_drain),
    .full_o  (fpu_full),
    .req_o   (fpu_req)
  );

  fpu_ss_wb_buffer u_mem_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (mem_valid_i),
    .ready_o (mem_ready_o),
    .req_i   (mem_req_in),
    .drain_i (mem_drain),
    .full_o  (mem_full),
    .req_o   (mem_req)
  );

  // Same-rd conflicts follow age to keep WAW order; otherwise round-robin.
  always_comb begin
    grant_vld = fpu_full | mem_full;
    grant     = WB_SRC_FPU;
    rr_last_d = rr_last_q;
    if (fpu_full && mem_full) begin
      if (fpu_req.rd == mem_req.rd) begin
        grant = age_q ? WB_SRC_MEM : WB_SRC_FPU;
      end else begin
        grant     = (rr_last_q == WB_SRC_MEM) ? WB_SRC_FPU : WB_SRC_MEM;
        rr_last_d = grant;
      end
    end else if (mem_full) begin
      grant = WB_SRC_MEM;
    end
    fpu_drain = grant_vld & (grant == WB_SRC_FPU);
    mem_drain = grant_vld & (grant == WB_SRC_MEM);
  end

  always_comb begin
    rf_we_o    = grant_vld;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (fpu_drain) begin
      rf_waddr_o = fpu_req.rd;
      rf_wdata_o = fpu_req.data;
    end else if (mem_drain) begin
      rf_waddr_o = mem_req.rd;
      rf_wdata_o = mem_req.data;
    end
  end

  // Age is captured only when the other entry stays resident past this edge.
  always_comb begin
    fpu_load = fpu_valid_i & fpu_ready_o;
    mem_load = mem_valid_i & mem_ready_o;
    age_d    = age_q;
    if (fpu_load && mem_full && !mem_drain) begin
      age_d = 1'b1;
    end else if (mem_load && fpu_full && !fpu_drain) begin
      age_d = 1'b0;
    end
  end

  // Set after clear so a same-cycle issue to the written rd stays pending.
  always_comb begin
    sb_d = sb_q;
    if (rf_we_o) begin
      sb_d[rf_waddr_o] = 1'b0;
    end
    if (issue_valid_i) begin
      sb_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= WB_SRC_MEM;
      age_q     <= 1'b0;
      sb_q      <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      age_q     <= age_d;
      sb_q      <= sb_d;
    end
  end

  assign sb_busy_o = sb_q;

`ifdef FPU_SS_WB_FWD_EN
  always_comb begin
    fwd_hit_o = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      fwd_hit_o[k] = rf_we_o & (rf_waddr_o == fwd_raddr_i[k]);
    end
    fwd_data_o = rf_wdata_o;
  end
`endif

`ifndef SYNTHESIS
  // Issue logic must stall on a pending destination.
  a_issue_no_hazard: assert property (
    @(posedge clk_i) disable iff (rst_i) issue_valid_i |-> !sb_q[issue_rd_i]
  );
`endif

endmodule
